// File: rtl/mips_multicycle_control_pkg.sv
// mips_multicycle_control_pkg: opcodes, state encodings and datapath select codes
// shared by the control FSM, the ALU decoder and the bench.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_mem_wait_timer.sv
// mips_multicycle_control_mem_wait_timer: 8-bit wait counter, flags the last allowed wait cycle.
module mips_multicycle_control_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 8'd1;

    assign expired = cnt == 8'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM with bounded memory handshakes.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       bus_error,
    output logic [3:0] state
);
    state_t cur, nxt;
    logic   expired, timeout, bus_err_nxt;

    // Counter restarts on every state change, so each memory state gets a fresh budget.
    mips_multicycle_control_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timeout || nxt != cur),
        .en      (!mem_ready),
        .expired (expired)
    );

    assign timeout = is_mem_state(cur) && expired && !mem_ready;
    assign state   = cur;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur       <= S_FETCH;
            bus_error <= 1'b0;
        end else begin
            cur       <= nxt;
            bus_error <= bus_err_nxt;
        end

    always_comb begin
        nxt         = S_FETCH;
        bus_err_nxt = 1'b0;
        case (cur)
            S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_RTYPEEX;
                    OP_BEQ:       nxt = S_BEQEX;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JEX;
                    default:      bus_err_nxt = 1'b1;
                endcase
            S_MEMADR:  nxt = opcode == OP_LW ? S_MEMRD : opcode == OP_SW ? S_MEMWR : S_FETCH;
            S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nxt = S_RTYPEWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
        if (timeout) begin
            nxt         = S_FETCH;
            bus_err_nxt = 1'b1;
        end
    end

    always_comb begin
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE:  alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:  reg_write = 1'b1;
            S_JEX: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds state at FETCH, whose MemReady-qualified enables must stay quiet.
        if (!rst_n) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed and random instruction streams checked against
// a transaction-level model of the control sequence.
module tb_mips_multicycle_control;
    import mips_multicycle_control_pkg::*;

    localparam int TMO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       rd, m2r, rw, iod, mr, mw, irw, pce;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb, aop;
        logic       be;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       reg_dst, mem_to_reg, reg_write, i_or_d, mem_read, mem_write, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, bus_error;
    logic [3:0] state;
    obs_t       obs;

    int  errors = 0;
    int  checks = 0;
    bit  pend = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .bus_error(bus_error), .state(state)
    );

    assign obs = {state, reg_dst, mem_to_reg, reg_write, i_or_d, mem_read, mem_write,
                  ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op, bus_error};

    function automatic obs_t row(input state_t s);
        obs_t e = '0;
        e.st = s;
        case (s)
            S_FETCH:   begin e.mr = 1; e.asb = 2'b01; end
            S_DECODE:  e.asb = 2'b11;
            S_MEMADR:  begin e.asa = 1; e.asb = 2'b10; end
            S_MEMRD:   begin e.mr = 1; e.iod = 1; end
            S_MEMWB:   begin e.rw = 1; e.m2r = 1; end
            S_MEMWR:   begin e.mw = 1; e.iod = 1; end
            S_RTYPEEX: begin e.asa = 1; e.aop = 2'b10; end
            S_RTYPEWB: begin e.rw = 1; e.rd = 1; end
            S_BEQEX:   begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; end
            S_ADDIEX:  begin e.asa = 1; e.asb = 2'b10; end
            S_ADDIWB:  e.rw = 1;
            S_JEX:     begin e.pcs = 2'b10; e.pce = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input obs_t e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at the falling edge.
    task automatic cyc(input obs_t e, input logic r, input logic z, input string tag);
        mem_ready = r;
        zero = z;
        @(negedge clk);
        check(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input state_t s);
        obs_t e = row(s);
        e.be = pend;
        pend = 0;
        cyc(e, 1'($urandom), 1'($urandom), s.name());
    endtask

    // A memory step: w low-MemReady cycles before ready; w >= TMO means a timeout.
    task automatic do_mem(input state_t s, input int w, output bit ok);
        bit done = 0;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            if (!done) begin
                obs_t e = row(s);
                bit   r = (i >= w);
                e.be = pend;
                pend = 0;
                if (s == S_FETCH) begin e.irw = r; e.pce = r; end
                cyc(e, r, 1'($urandom), s.name());
                if (r) begin ok = 1; done = 1; end
                else if (i == TMO - 1) begin pend = 1; done = 1; end
            end
        end
    endtask

    task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        bit   ok;
        obs_t e;
        opcode = op;
        do_mem(S_FETCH, fw, ok);
        if (!ok) do_mem(S_FETCH, 0, ok);
        one(S_DECODE);
        case (op)
            6'h00: begin one(S_RTYPEEX); one(S_RTYPEWB); end
            6'h23: begin one(S_MEMADR); do_mem(S_MEMRD, mw, ok); if (ok) one(S_MEMWB); end
            6'h2B: begin one(S_MEMADR); do_mem(S_MEMWR, mw, ok); end
            6'h04: begin
                e = row(S_BEQEX);
                e.pce = z;
                cyc(e, 1'($urandom), z, "BEQEX");
            end
            6'h08: begin one(S_ADDIEX); one(S_ADDIWB); end
            6'h02: one(S_JEX);
            default: pend = 1;
        endcase
    endtask

    initial begin
        obs_t rst_row;
        bit   ok;
        rst_row = row(S_FETCH);
        rst_row.mr = 0;
        mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check(rst_row, "reset");
        rst_n = 1;
        // add, then illegal opcode, then lw with a 3-cycle read wait
        instr(6'h00, 0, 0, 0);
        instr(6'h3F, 0, 0, 0);
        instr(6'h23, 1, 3, 0);
        instr(6'h04, 0, 0, 1);
        instr(6'h04, 2, 0, 0);
        instr(6'h2B, 0, TMO, 0);
        instr(6'h2B, 0, TMO - 1, 0);
        instr(6'h08, TMO, 0, 0);
        instr(6'h02, 0, 0, 0);
        // reset asserted asynchronously while MEMRD waits
        opcode = 6'h23;
        do_mem(S_FETCH, 0, ok);
        one(S_DECODE);
        one(S_MEMADR);
        mem_ready = 0;
        @(negedge clk);
        check(row(S_MEMRD), "memrd_pre_reset");
        #2 rst_n = 0;
        #1 check(rst_row, "reset_mid_memrd");
        mem_ready = 1;
        @(posedge clk);
        #1 check(rst_row, "reset_held");
        rst_n = 1;
        pend = 0;
        instr(6'h00, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
            int k = $urandom_range(0, 6);
            instr(k == 6 ? 6'($urandom) : ops[k], $urandom_range(0, TMO + 1) % (TMO + 2),
                  $urandom_range(0, TMO + 1), 1'($urandom));
        end
        instr(6'h02, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
